// File: rtl/alu_vector_checker.sv
// On-chip ALU regression checker: replays stored 100-bit vectors {f,a,b,y,zero}
// through an external combinational ALU and counts result mismatches.
module alu_vector_checker #(
  parameter int NUM_VECTORS = 21,
  parameter int ADDR_W      = 5,
  parameter int SETTLE      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_we,
  input  logic [ADDR_W-1:0] vec_waddr,
  input  logic [99:0]       vec_wdata,
  input  logic              start,
  output logic [2:0]        alu_f,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_y,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_vld
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t             r_state;
  logic [99:0]        r_mem [NUM_VECTORS];
  logic [99:0]        r_vec;
  logic [ADDR_W-1:0]  r_idx;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic [2:0]         r_alu_f;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_err_count;
  logic [ADDR_W-1:0]  r_first_fail_idx;
  logic               r_first_fail_vld;

  logic               w_wr_ok;
  logic               w_mismatch;
  logic               w_last;

  // Writes are locked out during a run so the vectors under test cannot change.
  assign w_wr_ok    = vec_we && !r_busy &&
                      ({1'b0, vec_waddr} < (ADDR_W+1)'(NUM_VECTORS));
  assign w_mismatch = (alu_y != r_vec[32:1]) || (alu_zero != r_vec[0]);
  assign w_last     = (r_idx == ADDR_W'(NUM_VECTORS - 1));

  // NOTE: the vector store has no reset so it maps onto plain RAM; contents
  // survive rst_n and are only changed through the write port.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[vec_waddr] <= vec_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_vec            <= '0;
      r_idx            <= '0;
      r_settle_cnt     <= '0;
      r_alu_f          <= '0;
      r_alu_a          <= '0;
      r_alu_b          <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_count      <= '0;
      r_first_fail_idx <= '0;
      r_first_fail_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_err_count      <= '0;
            r_first_fail_idx <= '0;
            r_first_fail_vld <= 1'b0;
            r_done           <= 1'b0;
            r_idx            <= '0;
            r_busy           <= 1'b1;
            r_state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_vec   <= r_mem[r_idx];
          r_state <= S_DRIVE;
        end
        S_DRIVE: begin
          r_alu_f <= r_vec[99:97];
          r_alu_a <= r_vec[96:65];
          r_alu_b <= r_vec[64:33];
          if (SETTLE == 0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle_cnt <= CNT_W'(SETTLE - 1);
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_settle_cnt == '0) r_state <= S_CHECK;
          else                    r_settle_cnt <= r_settle_cnt - 1'b1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            if (!r_first_fail_vld) begin
              r_first_fail_idx <= r_idx;
              r_first_fail_vld <= 1'b1;
            end
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_f          = r_alu_f;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_count      = r_err_count;
  assign first_fail_idx = r_first_fail_idx;
  assign first_fail_vld = r_first_fail_vld;

endmodule
